// File: rtl/sar_search_sixteenbit_if.sv
// Search-engine <-> comparator bus: start request, comparator flags in,
// probe/status/result out. master = search engine, slave = comparator/host side.
interface sar_search_sixteenbit_if #(parameter int WIDTH = 16);
  logic             start;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [WIDTH-1:0] probe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       iters;
  logic             err;

  modport master (
    input  start, cmp_gt, cmp_lt, cmp_eq,
    output probe, busy, done, result, iters, err
  );

  modport slave (
    output start, cmp_gt, cmp_lt, cmp_eq,
    input  probe, busy, done, result, iters, err
  );
endinterface

// File: rtl/sar_search_sixteenbit.sv
// MSB-first successive-approximation search against an external magnitude
// comparator holding the target; one compare per cycle, done pulse on exit.
module sar_search_sixteenbit #(
  parameter int WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  sar_search_sixteenbit_if.master bus
);
  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_TOP = KW'(WIDTH - 1);
  localparam logic [KW-1:0] K_ONE = KW'(1);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] probe_q, probe_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic [4:0]       iters_q, iters_d;
  logic             err_q, err_d;
  logic             one_hot;

  assign one_hot = (({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b100) ||
                    ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b010) ||
                    ({bus.cmp_gt, bus.cmp_lt, bus.cmp_eq} == 3'b001));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      probe_q  <= '0;
      result_q <= '0;
      k_q      <= '0;
      iters_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      probe_q  <= probe_d;
      result_q <= result_d;
      k_q      <= k_d;
      iters_q  <= iters_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    probe_d  = probe_q;
    result_d = result_q;
    k_d      = k_q;
    iters_d  = iters_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d              = S_SEARCH;
          probe_d              = '0;
          probe_d[WIDTH-1]     = 1'b1;
          k_d                  = K_TOP;
          iters_d              = '0;
          err_d                = 1'b0;
        end
      end
      S_SEARCH: begin
        iters_d = iters_q + 5'd1;
        state_d = S_DONE;
        if (!one_hot) begin
          err_d    = 1'b1;
          result_d = probe_q;
        end else if (bus.cmp_eq) begin
          result_d = probe_q;
        end else if (k_q == '0) begin
          // gt on the last trial bit means the comparator contradicted itself
          result_d = probe_q;
          if (bus.cmp_lt) result_d[0] = 1'b0;
          else            err_d       = 1'b1;
        end else begin
          state_d = S_SEARCH;
          if (bus.cmp_lt) probe_d[k_q] = 1'b0;
          probe_d[k_q - K_ONE] = 1'b1;
          k_d = k_q - K_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.probe  = probe_q;
  assign bus.busy   = (state_q == S_SEARCH);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.iters  = iters_q;
  assign bus.err    = err_q;
endmodule

// File: tb/tb_sar_search_sixteenbit.sv
// Directed bench: behavioural comparator (A=target, B=probe) with flag-fault injection.
module tb_sar_search_sixteenbit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] target = '0;
  logic        inj = 1'b0;
  int          checks = 0;
  int          errors = 0;
  int          ncmp;

  sar_search_sixteenbit_if #(.WIDTH(16)) bus ();

  sar_search_sixteenbit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.cmp_gt = inj ? 1'b1 : (target > bus.probe);
    bus.cmp_lt = inj ? 1'b1 : (target < bus.probe);
    bus.cmp_eq = inj ? 1'b0 : (target == bus.probe);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mode 1: expect walking-one probes (target 0); mode 2: expect filling-ones probes
  task automatic run(input logic [15:0] tgt, input int mode, input int inj_at,
                     input bit hold, output int n);
    bit          seen = 0;
    logic [15:0] e;
    target = tgt;
    n = 0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    chk("busy_on", bus.busy, 1);
    chk("err_clr", bus.err, 0);
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (c <= 16 && mode == 1) begin
        e = 16'h8000 >> (c - 1);
        chk("probe_walk", bus.probe, e);
      end
      if (c <= 16 && mode == 2) begin
        e = 16'hFFFF << (16 - c);
        chk("probe_fill", bus.probe, e);
      end
      if (c == inj_at) inj = 1'b1;
      @(posedge clk); #1;
      inj = 1'b0;
      if (bus.done) begin
        seen = 1;
        n = c;
      end
    end
    if (!seen) chk("timeout", 0, 1);
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("done_1cyc", bus.done, 0);
    chk("idle", bus.busy, 0);
  endtask

  task automatic expect_res(input string tag, input int n, input logic [15:0] res,
                            input int it, input bit er);
    chk({tag, "_lat"}, n, it);
    chk({tag, "_res"}, bus.result, res);
    chk({tag, "_iters"}, bus.iters, it);
    chk({tag, "_err"}, bus.err, er);
  endtask

  initial begin
    bit done_seen;
    bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_probe", bus.probe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_iters", bus.iters, 0);
    chk("rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(16'h8000, 0, 0, 0, ncmp); expect_res("t1", ncmp, 16'h8000, 1, 0);
    run(16'h0000, 1, 0, 0, ncmp); expect_res("t2", ncmp, 16'h0000, 16, 0);
    run(16'hFFFF, 2, 0, 0, ncmp); expect_res("t3", ncmp, 16'hFFFF, 16, 0);
    run(16'h1234, 0, 0, 1, ncmp); expect_res("t4", ncmp, 16'h1234, 14, 0);
    run(16'h0001, 0, 0, 0, ncmp); expect_res("t4b2b", ncmp, 16'h0001, 16, 0);
    run(16'h1234, 0, 3, 0, ncmp); expect_res("t5", ncmp, 16'h2000, 3, 1);
    run(16'h0100, 0, 0, 0, ncmp); expect_res("t5clr", ncmp, 16'h0100, 8, 0);

    // reset in the middle of a full-length search
    target = 16'h0000;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("t6_iters_pre", bus.iters, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_probe", bus.probe, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_result", bus.result, 0);
    chk("t6_iters", bus.iters, 0);
    chk("t6_err", bus.err, 0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen = 1;
    end
    chk("t6_nodone", done_seen, 0);
    @(negedge clk); rst_n = 1'b1;
    run(16'hA5A0, 0, 0, 0, ncmp); expect_res("t6new", ncmp, 16'hA5A0, 11, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
